// File: rtl/led_pkg.sv
// Shared LED time-base definitions: FSM state encodings and the tick divider
// derivation, so every LED block counts on the same prescaled period.
package led_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_OFF  = 2'd2;

  function automatic int tick_div(input int clk_freq, input int tick_hz);
    return clk_freq / tick_hz;
  endfunction

endpackage

// File: rtl/led_blink_sequencer_if.sv
// Command port of the blink sequencer: valid/ready handshake carrying the
// on/off phase lengths (ticks) and the repeat count (0 = forever).
interface led_blink_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             valid;
  logic             ready;
  logic [CNT_W-1:0] on_len;
  logic [CNT_W-1:0] off_len;
  logic [CNT_W-1:0] rep;

  modport master (output valid, on_len, off_len, rep, input ready);
  modport slave  (input valid, on_len, off_len, rep, output ready);
endinterface

// File: rtl/tick_gen.sv
// Prescaler emitting a one-cycle tick every DIV cycles. Down-counter with
// terminal-count compare; restart realigns the period to the current cycle.
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int          W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LOAD = W'(DIV - 1);

  logic [W-1:0] cnt;

  // LOAD corresponds to the start of a period, so tick lands DIV-1 cycles later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= LOAD;
    end else if (restart || cnt == '0) begin
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/led_blink_sequencer.sv
// Command-driven single-LED blink controller with on/off/repeat sequencing.
// Optional LED_ACTIVE_LOW_EN inverts the LED pin (reset value 1, lit = 0).
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no sequence; command port ready unless abort
// ON      | LED lit, counting on_len ticks
// OFF     | LED dark, counting off_len ticks, then repeat/finish
module led_blink_sequencer
  import led_pkg::*;
#(
  parameter int CLK_FREQ = 125_000_000,
  parameter int TICK_HZ  = 10,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  led_blink_sequencer_if.slave  cmd,
  input  logic                  abort,
  output logic                  led,
  output logic                  busy,
  output logic                  done
);

  localparam int               TICK_DIV = tick_div(CLK_FREQ, TICK_HZ);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [1:0]       state;
  logic [CNT_W-1:0] on_len;
  logic [CNT_W-1:0] off_len;
  logic [CNT_W-1:0] rep_len;
  logic [CNT_W-1:0] phase_cnt;
  logic [CNT_W-1:0] blink_cnt;
  logic             led_q;
  logic             tick;
  logic             accept;
  logic             on_last;
  logic             off_last;
  logic             blink_last;

  assign cmd.ready  = (state == ST_IDLE) && !abort;
  assign accept     = cmd.valid && cmd.ready;
  assign on_last    = (phase_cnt == on_len - ONE);
  assign off_last   = (phase_cnt == off_len - ONE);
  assign blink_last = (blink_cnt == rep_len - ONE);

  tick_gen #(.DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (accept),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      on_len    <= '0;
      off_len   <= '0;
      rep_len   <= '0;
      phase_cnt <= '0;
      blink_cnt <= '0;
      led_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && abort) begin
        state <= ST_IDLE;
        led_q <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              // zero-length phases would never terminate, so they run as one tick
              on_len    <= (cmd.on_len == '0) ? ONE : cmd.on_len;
              off_len   <= (cmd.off_len == '0) ? ONE : cmd.off_len;
              rep_len   <= cmd.rep;
              phase_cnt <= '0;
              blink_cnt <= '0;
              led_q     <= 1'b1;
              busy      <= 1'b1;
              state     <= ST_ON;
            end
          end
          ST_ON: begin
            if (tick) begin
              if (on_last) begin
                phase_cnt <= '0;
                led_q     <= 1'b0;
                state     <= ST_OFF;
              end else begin
                phase_cnt <= phase_cnt + ONE;
              end
            end
          end
          ST_OFF: begin
            if (tick) begin
              if (off_last) begin
                phase_cnt <= '0;
                if (rep_len == '0) begin
                  led_q <= 1'b1;
                  state <= ST_ON;
                end else if (blink_last) begin
                  led_q <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_IDLE;
                end else begin
                  blink_cnt <= blink_cnt + ONE;
                  led_q     <= 1'b1;
                  state     <= ST_ON;
                end
              end else begin
                phase_cnt <= phase_cnt + ONE;
              end
            end
          end
          default: begin
            led_q <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~led_q;
`else
  assign led = led_q;
`endif

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer at CLK_FREQ=100, TICK_HZ=10 (10-cycle tick).
// Expected LED/BUSY/DONE waveforms come from a cycle-index model of the sequence.
module tb_led_blink_sequencer;

  localparam int P     = 10;
  localparam int CNT_W = 8;
`ifdef LED_ACTIVE_LOW_EN
  localparam logic LED_ON = 1'b0;
`else
  localparam logic LED_ON = 1'b1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic abort;
  logic led;
  logic busy;
  logic done;
  logic led_lit;
  int   vectors = 0;
  int   miscompares = 0;

  led_blink_sequencer_if #(.CNT_W(CNT_W)) cmd_if ();

  led_blink_sequencer #(.CLK_FREQ(100), .TICK_HZ(10), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cmd_if),
    .abort (abort),
    .led   (led),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  assign led_lit = (led === LED_ON);

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // {led_lit, busy, done} i cycles after the accept edge; reps==0 runs forever
  function automatic logic [2:0] exp_state(input int on_t, input int off_t,
                                           input int reps, input int i);
    int per;
    int total;
    per   = (on_t + off_t) * P;
    total = reps * per;
    if (reps == 0 || i < total) return {((i % per) < on_t * P), 1'b1, 1'b0};
    return {1'b0, 1'b0, (i == total)};
  endfunction

  task automatic drive_cmd(input int on_t, input int off_t, input int reps);
    cmd_if.valid   = 1'b1;
    cmd_if.on_len  = CNT_W'(on_t);
    cmd_if.off_len = CNT_W'(off_t);
    cmd_if.rep     = CNT_W'(reps);
  endtask

  task automatic check_seq(input int on_t, input int off_t, input int reps);
    int total;
    total = reps * (on_t + off_t) * P;
    for (int i = 0; i <= total + 1; i++) begin
      check("seq", {29'd0, led_lit, busy, done}, {29'd0, exp_state(on_t, off_t, reps, i)});
      step(1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    abort = 1'b0;
    cmd_if.valid = 1'b0;
    cmd_if.on_len = '0;
    cmd_if.off_len = '0;
    cmd_if.rep = '0;

    // 1: reset and release
    step(3);
    check("rst_led", {31'd0, led_lit}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    step(2);
    check("idle_state", {29'd0, led_lit, busy, done}, 32'd0);
    check("idle_ready", {31'd0, cmd_if.ready}, 32'd1);

    // 2: on=2 off=3 repeat=2, DONE 100 cycles after accept
    drive_cmd(2, 3, 2);
    step(1);
    cmd_if.valid = 1'b0;
    check("busy_ready", {31'd0, cmd_if.ready}, 32'd0);
    check_seq(2, 3, 2);

    // 3: forever blink, abort after 7 periods
    drive_cmd(1, 1, 0);
    step(1);
    cmd_if.valid = 1'b0;
    for (int i = 0; i < 70; i++) begin
      check("forever", {29'd0, led_lit, busy, done}, {29'd0, exp_state(1, 1, 0, i)});
      step(1);
    end
    abort = 1'b1;
    step(1);
    check("abort_state", {29'd0, led_lit, busy, done}, 32'd0);
    check("abort_ready", {31'd0, cmd_if.ready}, 32'd0);
    abort = 1'b0;
    #1;
    check("post_abort_ready", {31'd0, cmd_if.ready}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      check("abort_no_done", {31'd0, done}, 32'd0);
      step(1);
    end

    // 4: repeat=3 with a dropped mid-sequence command, then a held command
    drive_cmd(1, 1, 3);
    step(1);
    cmd_if.valid = 1'b0;
    for (int i = 0; i <= 60; i++) begin
      if (i == 15) drive_cmd(5, 5, 1);
      if (i == 16) cmd_if.valid = 1'b0;
      if (i == 50) drive_cmd(1, 1, 1);
      #1;
      check("rep3", {29'd0, led_lit, busy, done}, {29'd0, exp_state(1, 1, 3, i)});
      if (i == 15 || (i >= 50 && i < 60)) check("drop_ready", {31'd0, cmd_if.ready}, 32'd0);
      if (i == 60) check("held_ready", {31'd0, cmd_if.ready}, 32'd1);
      step(1);
    end
    cmd_if.valid = 1'b0;
    check_seq(1, 1, 1);

    // 5: zero on/off fields behave as one tick each
    drive_cmd(0, 0, 1);
    step(1);
    cmd_if.valid = 1'b0;
    check_seq(1, 1, 1);

    // 6: async reset mid ON phase
    drive_cmd(3, 1, 1);
    step(1);
    cmd_if.valid = 1'b0;
    step(5);
    check("pre_rst_led", {31'd0, led_lit}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led", {31'd0, led_lit}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("post_rst_state", {29'd0, led_lit, busy, done}, 32'd0);
    check("post_rst_ready", {31'd0, cmd_if.ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
